// File: rtl/store_unit.sv
// Store unit: turns a size-coded store into one or two aligned, strobed memory write beats.
// Latency: accept at N; with mem_ready=1 beat0 at N+1, response at N+2 (one beat), N+3 (split), N+1 (error).
// Backpressure: one request in flight (req_ready only in IDLE); beats hold stable until mem_ready.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   req_valid/req_ready           - request handshake; funct3/addr/wdata are latched on acceptance
//   mem_valid/mem_ready           - write-beat handshake; mem_addr/mem_wdata/mem_wstrb describe the beat
//   resp_valid/resp_err           - one-cycle completion pulse; err set for rejected requests
module store_unit #(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic              resp_valid,
  output logic              resp_err
);
  localparam int NB  = XLEN / 8;
  localparam int LNB = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;

  // Decode of the incoming request, used only to decide rejection at acceptance.
  logic       in_illegal, in_misaligned;
  logic [3:0] in_off, in_sz_m1;

  assign in_illegal    = funct3[2] | ((funct3[1:0] == 2'b11) && (XLEN == 32));
  assign in_off        = 4'(addr[LNB-1:0]);
  assign in_sz_m1      = (4'd1 << funct3[1:0]) - 4'd1;
  assign in_misaligned = (in_off & in_sz_m1) != 4'd0;

  // Beat construction from the latched request. The strobe and data are built
  // across a double-width window so a store crossing the word boundary spills
  // naturally into the upper half, which becomes the second beat.
  logic [LNB-1:0]    off_q;
  logic [2*NB-1:0]   strb_base, strb_full;
  logic [2*XLEN-1:0] data_base, data_full;
  logic              need_beat1;
  logic [XLEN-1:0]   beat0_addr, beat1_addr;

  assign off_q = addr_q[LNB-1:0];

  always_comb begin
    strb_base = '0;
    data_base = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << funct3_q[1:0])) begin
        strb_base[i]        = 1'b1;
        data_base[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  assign strb_full  = strb_base << off_q;
  assign data_full  = data_base << {off_q, 3'b000};
  assign need_beat1 = |strb_full[2*NB-1:NB];
  assign beat0_addr = {addr_q[XLEN-1:LNB], {LNB{1'b0}}};
  assign beat1_addr = beat0_addr + XLEN'(NB);  // wraps modulo 2^XLEN

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          funct3_d = funct3;
          addr_d   = addr;
          wdata_d  = wdata;
          err_d    = in_illegal | (in_misaligned & !SPLIT_MISALIGNED);
          state_d  = err_d ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = beat0_addr;
        mem_wdata = data_full[XLEN-1:0];
        mem_wstrb = strb_full[NB-1:0];
        if (mem_ready) begin
          state_d = need_beat1 ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = beat1_addr;
        mem_wdata = data_full[2*XLEN-1:XLEN];
        mem_wstrb = strb_full[2*NB-1:NB];
        if (mem_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit (XLEN=32): one instance splits misaligned
// stores, a second instance rejects them. Inputs change and outputs are
// sampled on the falling edge; the DUT updates on the rising edge.
module tb_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_n;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        mem_ready;

  logic        req_ready, mem_valid, resp_valid, resp_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        req_ready_n, mem_valid_n, resp_valid_n, resp_err_n;
  logic [31:0] mem_addr_n, mem_wdata_n;
  logic [3:0]  mem_wstrb_n;

  int n_vec = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int resp_cnt = 0;

  always #5 clk = ~clk;

  store_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .resp_valid(resp_valid), .resp_err(resp_err)
  );

  store_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut_n (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_n), .req_ready(req_ready_n),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_valid(mem_valid_n), .mem_ready(mem_ready),
    .mem_addr(mem_addr_n), .mem_wdata(mem_wdata_n), .mem_wstrb(mem_wstrb_n),
    .resp_valid(resp_valid_n), .resp_err(resp_err_n)
  );

  always @(posedge clk) begin
    if (mem_valid && mem_ready) hs_cnt++;
    if (resp_valid) resp_cnt++;
  end

  // Presents one request for a single cycle; returns at the falling edge of cycle N+1.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, input bit to_n);
    @(negedge clk);
    funct3 = f;
    addr   = a;
    wdata  = d;
    if (to_n) req_valid_n = 1'b1;
    else      req_valid   = 1'b1;
    @(negedge clk);
    req_valid   = 1'b0;
    req_valid_n = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_valid_n = 1'b0; mem_ready = 1'b1;
    funct3 = 3'b010; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({req_ready, mem_valid, mem_wstrb, mem_addr, mem_wdata, resp_valid, resp_err} !==
        {1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b v=%b s=%b a=%h d=%h rv=%b re=%b want rdy=1 rest 0",
               req_ready, mem_valid, mem_wstrb, mem_addr, mem_wdata, resp_valid, resp_err);
    end
    n_vec++;
    if ({req_ready_n, mem_valid_n, mem_wstrb_n, resp_valid_n} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_state_nosplit: got %b want 1000000",
               {req_ready_n, mem_valid_n, mem_wstrb_n, resp_valid_n});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    logic [2:0]  tf [4];
    logic [31:0] ta [4], td [4], ea [4], ed [4];
    logic [3:0]  es [4];
    tf = '{3'b010, 3'b000, 3'b001, 3'b000};
    ta = '{32'h100, 32'h203, 32'h101, 32'h001};
    td = '{32'hDEADBEEF, 32'h123456AB, 32'h00001234, 32'hFFFFFF5A};
    ea = '{32'h100, 32'h200, 32'h100, 32'h000};
    es = '{4'b1111, 4'b1000, 4'b0110, 4'b0010};
    ed = '{32'hDEADBEEF, 32'hAB000000, 32'h00123400, 32'h00005A00};
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(tf[i], ta[i], td[i], 1'b0);
      n_vec++;
      if ({mem_valid, mem_addr, mem_wstrb, mem_wdata, resp_valid} !== {1'b1, ea[i], es[i], ed[i], 1'b0}) begin
        n_bad++;
        $display("FAIL single[%0d] beat0: got v=%b a=%h s=%b d=%h rv=%b want v=1 a=%h s=%b d=%h rv=0",
                 i, mem_valid, mem_addr, mem_wstrb, mem_wdata, resp_valid, ea[i], es[i], ed[i]);
      end
      @(negedge clk);
      n_vec++;
      if ({mem_valid, mem_wstrb, resp_valid, resp_err} !== {1'b0, 4'h0, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL single[%0d] resp: got v=%b s=%b rv=%b re=%b want v=0 s=0 rv=1 re=0",
                 i, mem_valid, mem_wstrb, resp_valid, resp_err);
      end
      @(negedge clk);
      n_vec++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        n_bad++;
        $display("FAIL single[%0d] idle: got rv=%b rdy=%b want rv=0 rdy=1", i, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_split();
    logic [2:0]  tf [3];
    logic [31:0] ta [3], td [3], ea0 [3], ed0 [3], ea1 [3], ed1 [3];
    logic [3:0]  es0 [3], es1 [3];
    tf  = '{3'b010, 3'b001, 3'b010};
    ta  = '{32'h102, 32'h103, 32'hFFFFFFFE};
    td  = '{32'hAABBCCDD, 32'h0000BEEF, 32'h11223344};
    ea0 = '{32'h100, 32'h100, 32'hFFFFFFFC};
    es0 = '{4'b1100, 4'b1000, 4'b1100};
    ed0 = '{32'hCCDD0000, 32'hEF000000, 32'h33440000};
    ea1 = '{32'h104, 32'h104, 32'h00000000};
    es1 = '{4'b0011, 4'b0001, 4'b0011};
    ed1 = '{32'h0000AABB, 32'h000000BE, 32'h00001122};
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(tf[i], ta[i], td[i], 1'b0);
      n_vec++;
      if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, ea0[i], es0[i], ed0[i]}) begin
        n_bad++;
        $display("FAIL split[%0d] beat0: got v=%b a=%h s=%b d=%h want v=1 a=%h s=%b d=%h",
                 i, mem_valid, mem_addr, mem_wstrb, mem_wdata, ea0[i], es0[i], ed0[i]);
      end
      @(negedge clk);
      n_vec++;
      if ({mem_valid, mem_addr, mem_wstrb, mem_wdata, resp_valid} !== {1'b1, ea1[i], es1[i], ed1[i], 1'b0}) begin
        n_bad++;
        $display("FAIL split[%0d] beat1: got v=%b a=%h s=%b d=%h rv=%b want v=1 a=%h s=%b d=%h rv=0",
                 i, mem_valid, mem_addr, mem_wstrb, mem_wdata, resp_valid, ea1[i], es1[i], ed1[i]);
      end
      @(negedge clk);
      n_vec++;
      if ({mem_valid, resp_valid, resp_err} !== 3'b010) begin
        n_bad++;
        $display("FAIL split[%0d] resp: got v=%b rv=%b re=%b want v=0 rv=1 re=0",
                 i, mem_valid, resp_valid, resp_err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_errors();
    logic [2:0] tf [3];
    tf = '{3'b011, 3'b100, 3'b111};
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(tf[i], 32'h100, 32'h55AA55AA, 1'b0);
      n_vec++;
      if ({mem_valid, mem_wstrb, resp_valid, resp_err} !== {1'b0, 4'h0, 1'b1, 1'b1}) begin
        n_bad++;
        $display("FAIL illegal[%0d] resp: got v=%b s=%b rv=%b re=%b want v=0 s=0 rv=1 re=1",
                 i, mem_valid, mem_wstrb, resp_valid, resp_err);
      end
      @(negedge clk);
      n_vec++;
      if ({mem_valid, resp_valid, req_ready} !== 3'b001) begin
        n_bad++;
        $display("FAIL illegal[%0d] idle: got v=%b rv=%b rdy=%b want 0 0 1", i, mem_valid, resp_valid, req_ready);
      end
    end
    // Non-splitting instance: misaligned stores are rejected, aligned ones proceed.
    issue(3'b010, 32'h102, 32'hAABBCCDD, 1'b1);
    n_vec++;
    if ({mem_valid_n, resp_valid_n, resp_err_n} !== 3'b011) begin
      n_bad++;
      $display("FAIL nosplit_sw_mis: got v=%b rv=%b re=%b want v=0 rv=1 re=1", mem_valid_n, resp_valid_n, resp_err_n);
    end
    @(negedge clk);
    issue(3'b001, 32'h101, 32'h00001234, 1'b1);
    n_vec++;
    if ({mem_valid_n, resp_valid_n, resp_err_n} !== 3'b011) begin
      n_bad++;
      $display("FAIL nosplit_sh_mis: got v=%b rv=%b re=%b want v=0 rv=1 re=1", mem_valid_n, resp_valid_n, resp_err_n);
    end
    @(negedge clk);
    issue(3'b010, 32'h104, 32'hCAFEF00D, 1'b1);
    n_vec++;
    if ({mem_valid_n, mem_addr_n, mem_wstrb_n, mem_wdata_n} !== {1'b1, 32'h104, 4'b1111, 32'hCAFEF00D}) begin
      n_bad++;
      $display("FAIL nosplit_aligned beat0: got v=%b a=%h s=%b d=%h want v=1 a=00000104 s=1111 d=cafef00d",
               mem_valid_n, mem_addr_n, mem_wstrb_n, mem_wdata_n);
    end
    @(negedge clk);
    n_vec++;
    if ({resp_valid_n, resp_err_n} !== 2'b10) begin
      n_bad++;
      $display("FAIL nosplit_aligned resp: got rv=%b re=%b want rv=1 re=0", resp_valid_n, resp_err_n);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int hs0;
    hs0 = hs_cnt;
    mem_ready = 1'b0;
    issue(3'b001, 32'h0FE, 32'h00005678, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({mem_valid, mem_addr, mem_wstrb, mem_wdata, resp_valid} !== {1'b1, 32'h0FC, 4'b1100, 32'h56780000, 1'b0}) begin
        n_bad++;
        $display("FAIL stall[%0d]: got v=%b a=%h s=%b d=%h rv=%b want v=1 a=000000fc s=1100 d=56780000 rv=0",
                 k, mem_valid, mem_addr, mem_wstrb, mem_wdata, resp_valid);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    n_vec++;
    if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h0FC, 4'b1100, 32'h56780000}) begin
      n_bad++;
      $display("FAIL stall_release: got v=%b a=%h s=%b d=%h want v=1 a=000000fc s=1100 d=56780000",
               mem_valid, mem_addr, mem_wstrb, mem_wdata);
    end
    @(negedge clk);
    n_vec++;
    if ({mem_valid, resp_valid, resp_err} !== 3'b010) begin
      n_bad++;
      $display("FAIL stall_resp: got v=%b rv=%b re=%b want v=0 rv=1 re=0", mem_valid, resp_valid, resp_err);
    end
    @(negedge clk);
    n_vec++;
    if (hs_cnt - hs0 !== 1) begin
      n_bad++;
      $display("FAIL stall_handshakes: got %0d want 1", hs_cnt - hs0);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = resp_cnt;
    mem_ready = 1'b0;
    issue(3'b010, 32'h100, 32'hDEADBEEF, 1'b0);
    n_vec++;
    if (mem_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_beat0 pre: got v=%b want 1", mem_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    n_vec++;
    if ({mem_valid, req_ready, resp_valid, mem_wstrb} !== 7'b0100000) begin
      n_bad++;
      $display("FAIL rst_beat0 post: got v=%b rdy=%b rv=%b s=%b want v=0 rdy=1 rv=0 s=0",
               mem_valid, req_ready, resp_valid, mem_wstrb);
    end
    repeat (3) @(negedge clk);
    issue(3'b010, 32'h102, 32'hAABBCCDD, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({mem_valid, mem_wstrb} !== 5'b10011) begin
      n_bad++;
      $display("FAIL rst_beat1 pre: got v=%b s=%b want v=1 s=0011", mem_valid, mem_wstrb);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({mem_valid, req_ready, resp_valid} !== 3'b010) begin
      n_bad++;
      $display("FAIL rst_beat1 post: got v=%b rdy=%b rv=%b want 0 1 0", mem_valid, req_ready, resp_valid);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (resp_cnt !== r0) begin
      n_bad++;
      $display("FAIL rst_no_resp: got %0d responses want 0", resp_cnt - r0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_split();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
